alu_arbiter: RTL
================

# alu_arbiter

Shares one 4-bit ALU datapath between two requesters. Each requester gets a valid/ready request port. The block arbitrates between them round-robin, sequences the chosen operation, and returns the result, status flag and requester ID on one valid/ready response port. Add, subtract and multiply take one execute cycle. Divide is iterative and takes WIDTH execute cycles. The block sits between the operand-producing control logic and the arithmetic datapath.

## Interface
- WIDTH, 4, operand and result width in bits; also the divide cycle count.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as the requester 0 ports, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  ID of the requester that owns the response.
- rsp_result  out  WIDTH  result.
- rsp_flag  out  1  status flag; meaning depends on the opcode (see Operation).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no reqN_valid is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational: state==IDLE && grantN. At most one ready is high per cycle.
  - On the handshake edge, capture a, b, sel and the ID, set last_grant to the granted ID, and go to EXEC.
- EXEC:
  - Add/sub/mul: compute in one cycle, register the result and flag, go to RESP.
  - Div with b!=0: run a restoring divider for WIDTH cycles, then go to RESP.
  - Div with b==0: one cycle, then go to RESP.
- RESP:
  - rsp_valid is high; rsp_id, rsp_result and rsp_flag hold stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Arithmetic (all results truncated to WIDTH bits):
  - Add: result = (a+b) mod 2^WIDTH; flag = carry-out.
  - Sub: result = (a-b) mod 2^WIDTH; flag = borrow (a<b).
  - Mul: result = low WIDTH bits of the 2·WIDTH-bit product; flag = high half nonzero.
  - Div: result = floor(a/b); remainder discarded; flag = 0.
  - Div by zero: result = all ones, flag = 1.
- Reset values: req0_ready=req1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flag=0, busy=0, state=IDLE, last_grant=1 (so requester 0 wins the first contention).
- Reset asserted mid-operation: the in-flight transaction is dropped and no response is ever produced for it.
- Requester valid deasserted after the handshake: no effect.
- Request inputs are ignored outside IDLE.

## Timing
- Handshake at cycle T (IDLE). EXEC at T+1.
- rsp_valid rises at T+2 for add, sub, mul and div by zero.
- rsp_valid rises at T+1+WIDTH for div with b!=0.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready held high.
- Back-to-back contention alternates grants 0,1,0,1.
- Backpressure: rsp_ready low holds RESP indefinitely; busy stays high for that time.

## Configuration
- ALU_ARB_DIV_EN defined: divide is built as described.
- ALU_ARB_DIV_EN undefined: the divider is not instantiated. sel=11 spends one EXEC cycle and returns result 0, flag 1 (illegal op). Latency matches the other ops.

## Structure
- Package alu_arb_pkg holds:
  - opcode enum OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - FSM state enum;
  - default WIDTH constant.
- Sub-module alu_div_seq: restoring divider with start/done, WIDTH cycles per divide, instantiated only under ALU_ARB_DIV_EN.
- Arbitration, the FSM and add/sub/mul live in the top module.

## Test plan
- Req0 add 9+8, rsp_ready=1 → ready at T, rsp_valid at T+2: id=0, result=1, flag=1.
- Both valid from reset: req0 sub 3-5, req1 mul 5*4 → req0 first (result=E, flag=1), then req1 (result=4, flag=1). Third contention grants req0.
- Req1 div 13/3 → result=4, flag=0, rsp_valid at T+1+WIDTH. Div 7/0 → result=F, flag=1 at T+2. Without ALU_ARB_DIV_EN, div → result=0, flag=1 at T+2.
- Hold rsp_ready=0 for 5 cycles in RESP → outputs stable, busy=1, no request accepted. Release → one handshake, then IDLE.
- Assert rst_n low during a divide's EXEC → all outputs at reset values immediately. No response after release; next request is served normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Opcode and FSM state encodings plus the default datapath width.
package alu_arb_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring divider, one quotient bit per cycle, WIDTH cycles per divide.
// The first step runs on the start edge, so o_done rises WIDTH-1 cycles later.
module alu_div_seq
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH-1:0] w_rem_src;
    logic [WIDTH-1:0] w_quo_src;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    assign w_rem_src = i_start ? '0  : r_rem;
    assign w_quo_src = i_start ? i_a : r_quo;
    assign w_b_src   = i_start ? i_b : r_b;

    // Shift in the next dividend bit; keep the difference only if non-negative.
    assign w_shift  = {w_rem_src, w_quo_src[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, w_b_src};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx = (w_quo_src << 1) | WIDTH'(w_ge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_b    <= i_b;
            r_cnt  <= CW'(WIDTH - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == '0);
    assign o_q    = r_quo;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Define ALU_ARB_DIV_EN to build the iterative divider; otherwise div is illegal.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             busy
);

    state_e           r_state;
    state_e           w_next;
    logic             r_last;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_sel;
    logic [WIDTH-1:0] r_result;
    logic             r_flag;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc;
    logic             w_gid;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [1:0]       w_sel_in;

    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res;
    logic             w_flag;
    logic             w_exec_done;

    // On contention the requester that did not win last time is served.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

    assign req0_ready = (r_state == ST_IDLE) && w_gnt0;
    assign req1_ready = (r_state == ST_IDLE) && w_gnt1;

    assign w_acc    = req0_ready || req1_ready;
    assign w_gid    = req1_ready;
    assign w_a_in   = w_gid ? req1_a   : req0_a;
    assign w_b_in   = w_gid ? req1_b   : req0_b;
    assign w_sel_in = w_gid ? req1_sel : req0_sel;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

`ifdef ALU_ARB_DIV_EN
    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_q;

    // Launched on the accept edge so the quotient is ready after WIDTH EXEC cycles.
    assign w_div_start = w_acc && (w_sel_in == 2'b11) && (w_b_in != '0);

    alu_div_seq #(
        .WIDTH   (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_a     (w_a_in),
        .i_b     (w_b_in),
        .o_done  (w_div_done),
        .o_q     (w_div_q)
    );
`endif

    always_comb begin
        w_res       = '0;
        w_flag      = 1'b0;
        w_exec_done = 1'b1;
        unique case (r_sel)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res  = r_a - r_b;
                w_flag = (r_a < r_b);
            end
            OP_MUL: begin
                w_res  = w_prod[WIDTH-1:0];
                w_flag = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
`ifdef ALU_ARB_DIV_EN
                if (r_b == '0) begin
                    w_res  = '1;
                    w_flag = 1'b1;
                end else begin
                    w_res       = w_div_q;
                    w_exec_done = w_div_done;
                end
`else
                w_flag = 1'b1;
`endif
            end
            default: begin
                w_res  = '0;
                w_flag = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_acc)       w_next = ST_EXEC;
            ST_EXEC: if (w_exec_done) w_next = ST_RESP;
            ST_RESP: if (rsp_ready)   w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= OP_ADD;
            r_result <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_last <= w_gid;
                r_id   <= w_gid;
                r_a    <= w_a_in;
                r_b    <= w_b_in;
                r_sel  <= op_e'(w_sel_in);
            end
            if ((r_state == ST_EXEC) && w_exec_done) begin
                r_result <= w_res;
                r_flag   <= w_flag;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_flag   = r_flag;

endmodule
